dma_master: RTL and testbench
=============================

# dma_master

Single-channel word-copy DMA engine for the SoC system bus. It connects to the bus's second master port (master 1) and moves a programmed number of 32-bit words from a source address to a destination address. It is configured through a timer-style register port driven by the bus's slave interface. Bus arbitration stalls are signalled by the bus `hold_flag`, and completion can raise an interrupt to the CPU.

## Interface
- `BASE_MASK`, default 32'hFFFF_FFFC: mask applied to SRC and DST on load; forces word alignment.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst_n`  in  1: reset; one clock, asynchronous, active-low.
- `dma_we`  in  1: config register write strobe from the bus.
- `dma_adr`  in  32: config register address; only bits [3:2] are decoded.
- `dma_wdata`  in  32: config write data.
- `dma_rdata`  out  32: config read data; combinational from `dma_adr`.
- `master1_request`  out  1: bus request; high in the RD and WR states.
- `master1_we`  out  1: 1 = write transfer, 0 = read transfer.
- `master1_adr`  out  32: transfer address.
- `master1_wdata`  out  32: write data, equal to the buffer in WR.
- `master1_rdata`  in  32: read data; valid combinationally in the same cycle as the request.
- `hold_flag`  in  1: bus is held by the other master; the current transfer does not complete this cycle.
- `int_sig`  out  1: completion interrupt (level).

## Operation
Registers, decoded from `dma_adr[3:2]`:
- 0 = SRC (RW)
- 1 = DST (RW)
- 2 = LEN (RW, word count)
- 3 = CTRL (RW):
  - bit0 START: write-1 pulse; reads 0.
  - bit1 BUSY: read-only.
  - bit2 DONE: write-1-to-clear.
  - bit3 IE: interrupt enable.

Register write rules:
- Writes to SRC, DST and LEN are ignored while BUSY=1.
- Writes with START=1 are ignored while BUSY=1.

State machine IDLE → RD → WR → (RD | IDLE):
- IDLE, START written:
  - If LEN==0: DONE←1, stay in IDLE; no bus traffic.
  - Otherwise: copy SRC, DST and LEN to working counters `cur_src`, `cur_dst`, `remain`; BUSY←1; go to RD.
- RD:
  - Drive request=1, we=0, adr=`cur_src`.
  - If `hold_flag`=0: `buf`←`master1_rdata`; go to WR.
  - Otherwise stay in RD; outputs unchanged.
- WR:
  - Drive request=1, we=1, adr=`cur_dst`, wdata=`buf`.
  - If `hold_flag`=0: `cur_src`+=4, `cur_dst`+=4, `remain`−=1.
    - If `remain` was 1: go to IDLE, BUSY←0, DONE←1.
    - Otherwise: go to RD.
  - Otherwise stay in WR.

Arithmetic and register behaviour:
- Address increments wrap modulo 2^32.
- LEN is 32-bit unsigned.
- SRC, DST and LEN registers are not modified by a transfer; they read back their programmed values.
- A DONE set and a W1C clear in the same cycle: set wins.
- In IDLE, `master1_request`, `master1_we`, `master1_adr` and `master1_wdata` are all 0.

## Timing
- Reset values:
  - All registers, counters and `buf` = 0; state = IDLE.
  - Outputs `master1_*`, `int_sig`, `dma_rdata` (at adr 0) = 0.
- START write accepted at edge E: request is asserted in the cycle after E.
- Each word takes 2 cycles plus the number of cycles `hold_flag` is high.
- N words with no holds: DONE is set at edge E+2N, and `int_sig` is high from the following cycle.
- Reset mid-transfer: the transfer is abandoned immediately; no partial state is retained.

## Configuration
- `DMA_IRQ_EN` defined:
  - IE is implemented.
  - `int_sig` = DONE & IE, registered.
- Not defined:
  - IE reads 0 and writes to it are ignored.
  - `int_sig` is tied to 0; software polls DONE.

## Test plan
- SRC=0x100, DST=0x200, LEN=3, START with no hold → bus sequence:
  - RD 0x100, WR 0x200, RD 0x104, WR 0x204, RD 0x108, WR 0x208.
  - DONE=1 six cycles after the start edge.
- Same transfer with `hold_flag` high for 2 cycles during the first RD and 1 cycle during the second WR → address and data held steady during the stalls; done 3 cycles later than the no-hold case.
- LEN=0, START → DONE=1 the next cycle; `master1_request` never asserted.
- While BUSY: write SRC=0xDEAD and START=1 → both ignored; the transfer finishes with the original addresses.
- IE=1, transfer of 1 word → `int_sig` rises after DONE; write CTRL=0x4 → DONE and `int_sig` clear the next cycle. With `DMA_IRQ_EN` undefined, `int_sig` stays 0.
- Assert `rst_n`=0 mid-transfer (in WR) → request drops immediately, BUSY=0, all registers read 0.

Source files
------------

// File: rtl/dma_master.sv
// dma_master: single-channel word-copy DMA engine on bus master 1, configured via a register port.
// The IE bit and the completion interrupt exist only when DMA_IRQ_EN is defined.
module dma_master #(
    parameter logic [31:0] BASE_MASK = 32'hFFFF_FFFC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dma_we,
    input  logic [31:0] dma_adr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        master1_request,
    output logic        master1_we,
    output logic [31:0] master1_adr,
    output logic [31:0] master1_wdata,
    input  logic [31:0] master1_rdata,
    input  logic        hold_flag,
    output logic        int_sig
);
    typedef enum logic [1:0] {IDLE, RD, WR} state_e;
    state_e      state_q, state_d;
    logic [31:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
    logic [31:0] cur_src_q, cur_src_d, cur_dst_q, cur_dst_d, remain_q, remain_d, buf_q, buf_d;
    logic        done_q, done_d, ie_q, ie_d, int_q, int_d;
    logic        busy, wr_src, wr_dst, wr_len, wr_ctrl, start;
    logic        unused_adr;

    assign busy       = state_q != IDLE;
    assign wr_src     = dma_we && dma_adr[3:2] == 2'd0 && !busy;
    assign wr_dst     = dma_we && dma_adr[3:2] == 2'd1 && !busy;
    assign wr_len     = dma_we && dma_adr[3:2] == 2'd2 && !busy;
    assign wr_ctrl    = dma_we && dma_adr[3:2] == 2'd3;
    assign start      = wr_ctrl && dma_wdata[0] && !busy;
    assign unused_adr = ^{dma_adr[31:4], dma_adr[1:0]};

    assign dma_rdata = dma_adr[3:2] == 2'd0 ? src_q :
                       dma_adr[3:2] == 2'd1 ? dst_q :
                       dma_adr[3:2] == 2'd2 ? len_q :
                       {28'd0, ie_q, done_q, busy, 1'b0};

    assign master1_request = busy;
    assign master1_we      = state_q == WR;
    assign master1_adr     = state_q == RD ? cur_src_q : state_q == WR ? cur_dst_q : 32'd0;
    assign master1_wdata   = state_q == WR ? buf_q : 32'd0;
    assign int_sig         = int_q;

    always_comb begin
        state_d   = state_q;
        src_d     = wr_src ? dma_wdata & BASE_MASK : src_q;
        dst_d     = wr_dst ? dma_wdata & BASE_MASK : dst_q;
        len_d     = wr_len ? dma_wdata : len_q;
        cur_src_d = cur_src_q;
        cur_dst_d = cur_dst_q;
        remain_d  = remain_q;
        buf_d     = buf_q;
        // DONE is cleared first so a same-cycle completion set overrides it
        done_d    = wr_ctrl && dma_wdata[2] ? 1'b0 : done_q;
`ifdef DMA_IRQ_EN
        ie_d      = wr_ctrl ? dma_wdata[3] : ie_q;
        int_d     = done_q & ie_q;
`else
        ie_d      = 1'b0;
        int_d     = 1'b0;
`endif
        case (state_q)
            IDLE: if (start) begin
                if (len_q == 32'd0) begin
                    done_d = 1'b1;
                end else begin
                    cur_src_d = src_q;
                    cur_dst_d = dst_q;
                    remain_d  = len_q;
                    state_d   = RD;
                end
            end
            RD: if (!hold_flag) begin
                buf_d   = master1_rdata;
                state_d = WR;
            end
            WR: if (!hold_flag) begin
                cur_src_d = cur_src_q + 32'd4;
                cur_dst_d = cur_dst_q + 32'd4;
                remain_d  = remain_q - 32'd1;
                state_d   = remain_q == 32'd1 ? IDLE : RD;
                done_d    = remain_q == 32'd1 ? 1'b1 : done_d;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            cur_src_q <= '0;
            cur_dst_q <= '0;
            remain_q  <= '0;
            buf_q     <= '0;
            done_q    <= 1'b0;
            ie_q      <= 1'b0;
            int_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            cur_src_q <= cur_src_d;
            cur_dst_q <= cur_dst_d;
            remain_q  <= remain_d;
            buf_q     <= buf_d;
            done_q    <= done_d;
            ie_q      <= ie_d;
            int_q     <= int_d;
        end
    end
endmodule

// File: tb/tb_dma_master.sv
// tb_dma_master: directed and randomized copies checked against a memory/bus-sequence reference model.
module tb_dma_master;
    logic        clk = 1'b0, rst_n = 1'b0, dma_we = 1'b0, hold_flag = 1'b0;
    logic [31:0] dma_adr = '0, dma_wdata = '0, dma_rdata;
    logic        master1_request, master1_we, int_sig;
    logic [31:0] master1_adr, master1_wdata, master1_rdata;
    logic [31:0] seed, rv;
    logic [64:0] bus_q[$], exp_q[$];
    int          n_checks = 0, n_fail = 0, req_cnt = 0;
`ifdef DMA_IRQ_EN
    localparam logic IRQ = 1'b1;
`else
    localparam logic IRQ = 1'b0;
`endif
    localparam logic [31:0] MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    assign master1_rdata = mem(master1_adr);

    dma_master dut (
        .clk(clk), .rst_n(rst_n), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .master1_request(master1_request), .master1_we(master1_we),
        .master1_adr(master1_adr), .master1_wdata(master1_wdata), .master1_rdata(master1_rdata),
        .hold_flag(hold_flag), .int_sig(int_sig)
    );

    always #5 clk = ~clk;

    // Completed bus transfers: a request seen with hold low finishes at the next rising edge
    always @(negedge clk) if (rst_n && master1_request) begin
        req_cnt++;
        if (!hold_flag) bus_q.push_back({master1_we, master1_adr, master1_we ? master1_wdata : 32'd0});
    end

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        dma_adr = {28'd0, a, 2'b00};
        dma_wdata = d;
        dma_we = 1'b1;
        step();
        dma_we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        dma_adr = {28'd0, a, 2'b00};
        #1;
        d = dma_rdata;
    endtask

    task automatic expect_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
        exp_q = {};
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({1'b0, src + 32'(4 * i), 32'd0});
            exp_q.push_back({1'b1, dst + 32'(4 * i), mem(src + 32'(4 * i))});
        end
    endtask

    task automatic cmp_bus(input string tag);
        chk({tag, "_count"}, 65'(bus_q.size()), 65'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < bus_q.size(); i++) chk({tag, "_xfer"}, bus_q[i], exp_q[i]);
    endtask

    task automatic wait_done(input logic rnd_hold, output int cyc, output int holds);
        logic [31:0] c;
        cyc = 0;
        holds = 0;
        c = '0;
        while (cyc < 300 && !c[2]) begin
            hold_flag = rnd_hold ? ($urandom_range(0, 2) == 0) : 1'b0;
            holds += int'(hold_flag);
            step();
            hold_flag = 1'b0;
            cyc++;
            rd(2'd3, c);
        end
        chk("done_reached", 65'(c[2]), 65'd1);
    endtask

    initial begin
        int cyc, holds, len;
        logic [31:0] src, dst;
        seed = $urandom;
        #1;
        chk("rst_req", 65'(master1_request), 65'd0);
        chk("rst_adr", 65'(master1_adr), 65'd0);
        chk("rst_wdata", 65'(master1_wdata), 65'd0);
        chk("rst_int", 65'(int_sig), 65'd0);
        rd(2'd0, rv);
        chk("rst_rdata0", 65'(rv), 65'd0);
        step();
        @(negedge clk) rst_n = 1'b1;
        step();
        // Directed 3-word copy, no stalls
        wr(2'd0, 32'h100);
        wr(2'd1, 32'h200);
        wr(2'd2, 32'd3);
        bus_q = {};
        wr(2'd3, 32'h1);
        chk("req_after_start", 65'(master1_request), 65'd1);
        rd(2'd3, rv);
        chk("busy_set", 65'(rv), 65'h2);
        wait_done(1'b0, cyc, holds);
        chk("done_latency", 65'(cyc + 1), 65'd6 + 65'd1);
        expect_copy(32'h100, 32'h200, 3);
        cmp_bus("copy3");
        rd(2'd0, rv);
        chk("src_kept", 65'(rv), 65'h100);
        rd(2'd2, rv);
        chk("len_kept", 65'(rv), 65'd3);
        chk("idle_req", 65'(master1_request), 65'd0);
        // Same copy with 2 stalls in the first read and 1 in the second write
        wr(2'd3, 32'h4);
        bus_q = {};
        wr(2'd3, 32'h1);
        for (int k = 0; k < 9; k++) begin
            hold_flag = (k == 0 || k == 1 || k == 5);
            if (k == 1) chk("stall_rd_adr", {master1_we, master1_adr}, {1'b0, 32'h100});
            if (k == 5) chk("stall_wr", {master1_we, master1_adr, master1_wdata}, {1'b1, 32'h204, mem(32'h104)});
            if (k == 8) begin
                rd(2'd3, rv);
                chk("stall_not_early", 65'(rv[2]), 65'd0);
            end
            step();
        end
        hold_flag = 1'b0;
        rd(2'd3, rv);
        chk("stall_done", 65'(rv[2]), 65'd1);
        cmp_bus("stall");
        // Zero-length start completes at once without bus traffic
        wr(2'd3, 32'h4);
        wr(2'd2, 32'd0);
        req_cnt = 0;
        wr(2'd3, 32'h1);
        rd(2'd3, rv);
        chk("len0_ctrl", 65'(rv), 65'h4);
        step();
        step();
        chk("len0_no_req", 65'(req_cnt), 65'd0);
        // Writes to SRC and a second START while busy are ignored
        wr(2'd3, 32'h4);
        wr(2'd2, 32'd3);
        bus_q = {};
        wr(2'd3, 32'h1);
        wr(2'd0, 32'hDEAD);
        wr(2'd3, 32'h1);
        wait_done(1'b0, cyc, holds);
        cmp_bus("busy_ignore");
        rd(2'd0, rv);
        chk("busy_src", 65'(rv), 65'h100);
        step();
        step();
        chk("no_restart", 65'(master1_request), 65'd0);
        // Interrupt
        wr(2'd3, 32'h4);
        wr(2'd3, 32'h8);
        rd(2'd3, rv);
        chk("ie_read", 65'(rv), {61'd0, IRQ, 3'b000});
        wr(2'd2, 32'd1);
        wr(2'd3, 32'h9);
        step();
        step();
        rd(2'd3, rv);
        chk("irq_done", 65'(rv[2]), 65'd1);
        step();
        chk("irq_high", 65'(int_sig), 65'(IRQ));
        wr(2'd3, 32'h4);
        rd(2'd3, rv);
        chk("irq_done_clr", 65'(rv[2]), 65'd0);
        step();
        chk("irq_low", 65'(int_sig), 65'd0);
        // Randomized copies with random stalls; first one wraps the address space
        for (int t = 0; t < 6; t++) begin
            src = $urandom;
            dst = $urandom;
            if (t == 0) src = 32'hFFFF_FFF0 | (src & 32'hB);
            len = int'($urandom_range(1, 5));
            wr(2'd3, 32'h4);
            wr(2'd0, src);
            rd(2'd0, rv);
            chk("rnd_src_mask", 65'(rv), 65'(src & MASK));
            wr(2'd1, dst);
            wr(2'd2, 32'(len));
            bus_q = {};
            wr(2'd3, 32'h1);
            wait_done(1'b1, cyc, holds);
            chk("rnd_cycles", 65'(cyc), 65'(2 * len + holds));
            expect_copy(src & MASK, dst & MASK, len);
            cmp_bus("rnd");
        end
        // Reset in the middle of a write
        wr(2'd3, 32'h4);
        wr(2'd0, 32'h100);
        wr(2'd2, 32'd3);
        wr(2'd3, 32'h1);
        step();
        chk("pre_rst_wr", 65'(master1_we), 65'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", 65'(master1_request), 65'd0);
        chk("rst_mid_adr", 65'(master1_adr), 65'd0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), rv);
            chk("rst_mid_reg", 65'(rv), 65'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("post_rst_req", 65'(master1_request), 65'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
